// File: rtl/bt_baseband_top_if.sv
// Register-bank and radio bit signals of the BR baseband, grouped for the block boundary.
// master = register bank / radio side that drives configuration and rxbit; slave = baseband core.
interface bt_baseband_top_if;
    logic        regi_isMaster;
    logic [27:0] regi_time_base_offset;
    logic [27:0] regi_slave_offset;
    logic        regi_InquiryEnable_oneshot;
    logic        regi_PageEnable_oneshot;
    logic        regi_InquiryScanEnable_oneshot;
    logic        regi_PageScanEnable_oneshot;
    logic [15:0] regi_Page_Timeout;
    logic [15:0] regi_Tiswindow;
    logic [15:0] regi_Tpswindow;
    logic [63:0] regi_syncword_GIAC;
    logic [63:0] regi_syncword_DAC;
    logic [5:0]  regi_correthreshold;
    logic        rxbit;
    logic        txbit;
    logic [6:0]  fk;
    logic [2:0]  state;
    logic        sync_hit_p;

    modport master (
        output regi_isMaster, regi_time_base_offset, regi_slave_offset,
               regi_InquiryEnable_oneshot, regi_PageEnable_oneshot,
               regi_InquiryScanEnable_oneshot, regi_PageScanEnable_oneshot,
               regi_Page_Timeout, regi_Tiswindow, regi_Tpswindow,
               regi_syncword_GIAC, regi_syncword_DAC, regi_correthreshold, rxbit,
        input  txbit, fk, state, sync_hit_p
    );

    modport slave (
        input  regi_isMaster, regi_time_base_offset, regi_slave_offset,
               regi_InquiryEnable_oneshot, regi_PageEnable_oneshot,
               regi_InquiryScanEnable_oneshot, regi_PageScanEnable_oneshot,
               regi_Page_Timeout, regi_Tiswindow, regi_Tpswindow,
               regi_syncword_GIAC, regi_syncword_DAC, regi_correthreshold, rxbit,
        output txbit, fk, state, sync_hit_p
    );
endinterface

// File: rtl/bt_baseband_top.sv
// BR baseband: native/piconet clock, link-state FSM, sync-word TX, RX correlator and hop index.
// State moves 1 clk after a oneshot; txbit/fk update on tick/CLKN edges; no backpressure (free-running bit stream).
module bt_baseband_top (
    input  logic             clk_6M,
    input  logic             rstz,
    bt_baseband_top_if.slave bb
);
    typedef enum logic [2:0] {
        ST_STANDBY   = 3'd0,
        ST_INQUIRY   = 3'd1,
        ST_PAGE      = 3'd2,
        ST_INQ_SCAN  = 3'd3,
        ST_PAGE_SCAN = 3'd4
    } link_state_e;

    link_state_e state_q, state_nx;
    logic [2:0]  div;
    logic [9:0]  us, us_nx;
    logic [27:0] clkn, clkn_nx, clk_pn, clk_pn_nx;
    logic [15:0] slot_cnt, slot_limit;
    logic [6:0]  guard_cnt, match_cnt, hop_sum, fk_nx, fk_q;
    logic [63:0] shreg, shreg_nx, sync_exp;
    logic        tick, slot_end, clkn_inc, slot_expired, is_scan;
    logic        rx_clean, hit_now, hit_q, tx_nx, txbit_q;
    logic        unused_clk_bits;

    assign tick      = (div == 3'd5);
    assign slot_end  = tick && (us == 10'd624);
    assign us_nx     = (us == 10'd624) ? 10'd0 : us + 10'd1;
    // Two CLKN increments per 625 us slot: at the slot wrap and at mid-slot (us becoming 312).
    assign clkn_inc  = tick && ((us == 10'd624) || (us == 10'd311));
    assign clkn_nx   = clkn + {27'd0, clkn_inc};
    assign clk_pn    = clkn + bb.regi_time_base_offset + (bb.regi_isMaster ? 28'd0 : bb.regi_slave_offset);
    assign clk_pn_nx = clk_pn + {27'd0, clkn_inc};
    assign unused_clk_bits = ^{clk_pn_nx[27:17], clk_pn_nx[11:4], clk_pn_nx[0]};

    assign is_scan      = (state_q == ST_INQ_SCAN) || (state_q == ST_PAGE_SCAN);
    assign slot_expired = slot_end && (({1'b0, slot_cnt} + 17'd1) >= {1'b0, slot_limit});

    always_comb begin
        slot_limit = 16'd0;
        case (state_q)
            ST_INQUIRY, ST_PAGE: slot_limit = bb.regi_Page_Timeout;
            ST_INQ_SCAN:         slot_limit = bb.regi_Tiswindow;
            ST_PAGE_SCAN:        slot_limit = bb.regi_Tpswindow;
            default:             slot_limit = 16'd0;
        endcase
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_STANDBY: begin
                if (bb.regi_isMaster) begin
                    if (bb.regi_InquiryEnable_oneshot)      state_nx = ST_INQUIRY;
                    else if (bb.regi_PageEnable_oneshot)    state_nx = ST_PAGE;
                end else begin
                    if (bb.regi_InquiryScanEnable_oneshot)  state_nx = ST_INQ_SCAN;
                    else if (bb.regi_PageScanEnable_oneshot) state_nx = ST_PAGE_SCAN;
                end
            end
            ST_INQUIRY, ST_PAGE:       if (slot_expired) state_nx = ST_STANDBY;
            ST_INQ_SCAN, ST_PAGE_SCAN: if (slot_expired || hit_q) state_nx = ST_STANDBY;
            default:                   state_nx = ST_STANDBY;
        endcase
    end

    // Anything but a clean 1 on the radio input counts as 0.
    always_comb begin
        rx_clean = 1'b0;
        if (bb.rxbit == 1'b1) rx_clean = 1'b1;
    end

    assign shreg_nx = {rx_clean, shreg[63:1]};
    assign sync_exp = (state_q == ST_INQ_SCAN) ? bb.regi_syncword_GIAC : bb.regi_syncword_DAC;

    always_comb begin
        match_cnt = 7'd0;
        for (int i = 0; i < 64; i++)
            if (shreg_nx[i] == sync_exp[i]) match_cnt = match_cnt + 7'd1;
    end

    // Correlation is judged on the register contents this tick produces; guard_cnt holds off the first 64 ticks.
    assign hit_now = tick && is_scan && (guard_cnt == 7'd64) && (match_cnt >= {1'b0, bb.regi_correthreshold});

    always_comb begin
        tx_nx = 1'b0;
        if (((state_nx == ST_INQUIRY) || (state_nx == ST_PAGE)) && !clk_pn_nx[1] && (us_nx < 10'd64))
            tx_nx = (state_nx == ST_INQUIRY) ? bb.regi_syncword_GIAC[us_nx[5:0]]
                                             : bb.regi_syncword_DAC[us_nx[5:0]];
    end

    assign hop_sum = {2'b00, clk_pn_nx[16:12]} + {1'b0, clk_pn_nx[3:2], 4'b0000};

    always_comb begin
        fk_nx = 7'd0;
        case (state_q)
            ST_INQUIRY, ST_PAGE:       fk_nx = (hop_sum >= 7'd79) ? hop_sum - 7'd79 : hop_sum;
            ST_INQ_SCAN, ST_PAGE_SCAN: fk_nx = {2'b00, clkn_nx[16:12]};
            default:                   fk_nx = 7'd0;
        endcase
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            div       <= 3'd0;
            us        <= 10'd0;
            clkn      <= 28'd0;
            slot_cnt  <= 16'd0;
            guard_cnt <= 7'd0;
            shreg     <= 64'd0;
            state_q   <= ST_STANDBY;
            txbit_q   <= 1'b0;
            fk_q      <= 7'd0;
            hit_q     <= 1'b0;
        end else begin
            state_q <= state_nx;
            hit_q   <= hit_now;
            div     <= tick ? 3'd0 : div + 3'd1;
            clkn    <= clkn_nx;
            if (tick) begin
                us      <= us_nx;
                shreg   <= shreg_nx;
                txbit_q <= tx_nx;
            end
            if (clkn_inc) fk_q <= fk_nx;
            if (state_nx != state_q) begin
                slot_cnt  <= 16'd0;
                guard_cnt <= 7'd0;
            end else begin
                if (slot_end) slot_cnt <= slot_cnt + 16'd1;
                if (tick && (guard_cnt != 7'd64)) guard_cnt <= guard_cnt + 7'd1;
            end
        end
    end

    assign bb.state      = state_q;
    assign bb.txbit      = txbit_q;
    assign bb.fk         = fk_q;
    assign bb.sync_hit_p = hit_q;
endmodule

// File: tb/tb_bt_baseband_top.sv
// Randomized bench for bt_baseband_top against a slot/us arithmetic model of clock, FSM, TX and correlator.
module tb_bt_baseband_top;
    localparam logic [63:0] GIAC = 64'h475c58cc73345e72;
    localparam logic [63:0] DAC  = 64'h7e7041e34000000d;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    bt_baseband_top_if bif();
    bt_baseband_top dut (.clk_6M(clk_6M), .rstz(rstz), .bb(bif.slave));

    initial forever #5 clk_6M = ~clk_6M;

    // Clock edges since reset release; tick T lands on edge 6*T.
    always @(posedge clk_6M or negedge rstz)
        if (!rstz) cyc <= 0;
        else       cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] clkn_at(input int t);
        return 28'(2 * (t / 625) + (((t % 625) >= 312) ? 1 : 0));
    endfunction

    function automatic logic [6:0] hop(input logic [27:0] c);
        int v;
        v = int'(c[16:12]) + 16 * int'(c[3:2]);
        return 7'(v % 79);
    endfunction

    task automatic wait_us_edge();
        do @(negedge clk_6M); while (cyc % 6 != 0);
    endtask

    task automatic fire(input int sel);
        bif.regi_InquiryEnable_oneshot     = (sel == 1);
        bif.regi_PageEnable_oneshot        = (sel == 2);
        bif.regi_InquiryScanEnable_oneshot = (sel == 3);
        bif.regi_PageScanEnable_oneshot    = (sel == 4);
        @(negedge clk_6M);
        bif.regi_InquiryEnable_oneshot     = 1'b0;
        bif.regi_PageEnable_oneshot        = 1'b0;
        bif.regi_InquiryScanEnable_oneshot = 1'b0;
        bif.regi_PageScanEnable_oneshot    = 1'b0;
    endtask

    task automatic do_reset();
        rstz = 1'b0;
        repeat (3) @(negedge clk_6M);
        rstz = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bif.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bif.state); end
        n_tests++; if (bif.txbit !== 1'b0) begin n_fail++; $display("FAIL reset_txbit: got %0b want 0", bif.txbit); end
        n_tests++; if (bif.fk !== 7'd0) begin n_fail++; $display("FAIL reset_fk: got %0d want 0", bif.fk); end
        n_tests++; if (bif.sync_hit_p !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", bif.sync_hit_p); end
        n_tests++; if (dut.clkn !== 28'd0) begin n_fail++; $display("FAIL reset_clkn: got %0h want 0", dut.clkn); end
        while (cyc / 6 < 1250) wait_us_edge();
        n_tests++; if (dut.clkn !== clkn_at(1250)) begin n_fail++; $display("FAIL clkn_1250: got %0d want %0d", dut.clkn, clkn_at(1250)); end
        n_tests++; if (dut.us !== 10'd0) begin n_fail++; $display("FAIL us_1250: got %0d want 0", dut.us); end
        n_tests++; if (bif.state !== 3'd0 || bif.txbit !== 1'b0 || bif.fk !== 7'd0) begin
            n_fail++; $display("FAIL idle_1250: state=%0d tx=%0b fk=%0d want 0/0/0", bif.state, bif.txbit, bif.fk); end
    endtask

    task automatic test_clk_offsets();
        logic [27:0] tbo, so, want;
        int t;
        so = 28'h0FFFFFF;
        bif.regi_slave_offset = so;
        for (int k = 0; k < 4; k++) begin
            tbo = (k == 0) ? 28'h0001000 : (k == 1) ? 28'hF001000 : 28'($urandom);
            bif.regi_time_base_offset = tbo;
            bif.regi_isMaster = (k == 3);
            repeat ($urandom_range(400, 50)) wait_us_edge();
            t = cyc / 6;
            want = 28'((longint'(clkn_at(t)) + longint'(tbo) + (k == 3 ? 0 : longint'(so))) % (longint'(1) << 28));
            n_tests++; if (dut.clkn !== clkn_at(t)) begin n_fail++; $display("FAIL clkn_model k=%0d: got %0h want %0h", k, dut.clkn, clkn_at(t)); end
            n_tests++; if (dut.clk_pn !== want) begin n_fail++; $display("FAIL clk_offset k=%0d: got %0h want %0h", k, dut.clk_pn, want); end
        end
    endtask

    task automatic test_role_ignore();
        for (int r = 0; r < 4; r++) begin
            bif.regi_isMaster = (r >= 2);
            wait_us_edge();
            fire(r + 1);
            repeat (12) begin
                @(negedge clk_6M);
                n_tests++; if (bif.state !== 3'd0) begin n_fail++; $display("FAIL role_ignore r=%0d: got state %0d want 0", r, bif.state); end
            end
        end
    endtask

    task automatic test_inquiry();
        logic [27:0] tbo, c;
        logic [6:0]  fk_exp;
        logic        tx_exp;
        bit          fk_known;
        int te, t_exit, t, u;
        tbo = 28'($urandom);
        bif.regi_isMaster = 1'b1;
        bif.regi_time_base_offset = tbo;
        bif.regi_slave_offset = 28'($urandom);
        bif.regi_Page_Timeout = 16'd3;
        wait_us_edge();
        te = cyc / 6;
        fire(1);
        n_tests++; if (bif.state !== 3'd1) begin n_fail++; $display("FAIL inq_entry: got %0d want 1", bif.state); end
        t_exit = (te / 625 + 3) * 625;
        fk_known = 1'b0;
        fk_exp = 7'd0;
        while (cyc / 6 < t_exit + 2) begin
            wait_us_edge();
            t = cyc / 6;
            u = t % 625;
            c = clkn_at(t) + tbo;
            tx_exp = (t < t_exit) && !c[1] && (u < 64) ? GIAC[u] : 1'b0;
            if (u == 0 || u == 312) begin
                fk_exp = (t <= t_exit) ? hop(c) : 7'd0;
                fk_known = 1'b1;
            end
            n_tests++; if (bif.state !== ((t < t_exit) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL inq_state t=%0d: got %0d", t, bif.state); end
            n_tests++; if (bif.txbit !== tx_exp) begin n_fail++; $display("FAIL inq_txbit t=%0d us=%0d: got %0b want %0b", t, u, bif.txbit, tx_exp); end
            if (fk_known) begin
                n_tests++; if (bif.fk !== fk_exp) begin n_fail++; $display("FAIL inq_fk t=%0d: got %0d want %0d", t, bif.fk, fk_exp); end
            end
        end
    endtask

    task automatic test_page();
        int te, t_exit, t, p;
        bif.regi_isMaster = 1'b1;
        for (int r = 0; r < 2; r++) begin
            p = (r == 0) ? 3 : 0;
            bif.regi_Page_Timeout = 16'(p);
            wait_us_edge();
            te = cyc / 6;
            fire(2);
            n_tests++; if (bif.state !== 3'd2) begin n_fail++; $display("FAIL page_entry p=%0d: got %0d want 2", p, bif.state); end
            t_exit = (te / 625 + ((p == 0) ? 1 : p)) * 625;
            while (cyc / 6 < t_exit + 3) begin
                wait_us_edge();
                t = cyc / 6;
                n_tests++; if (bif.state !== ((t < t_exit) ? 3'd2 : 3'd0)) begin
                    n_fail++; $display("FAIL page_state p=%0d t=%0d: got %0d want %0d", p, t, bif.state, (t < t_exit) ? 2 : 0); end
                if (t == te + 10 && t < t_exit) fire(1);
            end
        end
    endtask

    task automatic test_scan_correlator(input bit is_inq, input int nflip, input int win, input int thr, input int exp_hits);
        logic [63:0] word, mask, sent;
        logic [2:0]  code;
        bit          hist[$];
        bit          b, in_scan, exp_hit;
        int te, t_exit, nticks, t, m, hits;
        word = is_inq ? GIAC : DAC;
        code = is_inq ? 3'd3 : 3'd4;
        mask = 64'd0;
        while ($countones(mask) < nflip) mask[$urandom_range(63, 0)] = 1'b1;
        sent = word ^ mask;
        bif.regi_isMaster = 1'b0;
        bif.regi_correthreshold = 6'(thr);
        bif.regi_Tiswindow = 16'(win);
        bif.regi_Tpswindow = 16'(win);
        wait_us_edge();
        te = cyc / 6;
        fire(is_inq ? 3 : 4);
        n_tests++; if (bif.state !== code) begin n_fail++; $display("FAIL scan_entry: got %0d want %0d", bif.state, code); end
        t_exit = (te / 625 + win) * 625;
        nticks = (exp_hits > 0) ? 140 : (t_exit - te + 2);
        in_scan = 1'b1;
        hits = 0;
        for (int i = 0; i < nticks; i++) begin
            b = (i >= 70 && i < 134) ? sent[i - 70] : 1'($urandom);
            bif.rxbit = b;
            wait_us_edge();
            t = cyc / 6;
            hist.push_back(b);
            if (hist.size() > 64) void'(hist.pop_front());
            m = 0;
            for (int k = 0; k < hist.size(); k++) if (hist[k] == word[k]) m++;
            exp_hit = in_scan && (i >= 64) && (m >= thr);
            n_tests++; if (bif.sync_hit_p !== exp_hit) begin
                n_fail++; $display("FAIL scan_hit flips=%0d i=%0d: got %0b want %0b (matches=%0d)", nflip, i, bif.sync_hit_p, exp_hit, m); end
            n_tests++; if (bif.state !== ((in_scan && t < t_exit) ? code : 3'd0)) begin
                n_fail++; $display("FAIL scan_state flips=%0d i=%0d: got %0d", nflip, i, bif.state); end
            if (bif.sync_hit_p === 1'b1) hits++;
            if (exp_hit || t >= t_exit) in_scan = 1'b0;
        end
        bif.rxbit = 1'b0;
        @(negedge clk_6M);
        n_tests++; if (hits !== exp_hits) begin n_fail++; $display("FAIL scan_hit_count flips=%0d: got %0d want %0d", nflip, hits, exp_hits); end
        n_tests++; if (bif.state !== 3'd0) begin n_fail++; $display("FAIL scan_final_state flips=%0d: got %0d want 0", nflip, bif.state); end
    endtask

    task automatic test_reset_abort();
        bif.regi_isMaster = 1'b1;
        bif.regi_Page_Timeout = 16'd50;
        wait_us_edge();
        fire(2);
        repeat ($urandom_range(300, 20)) wait_us_edge();
        n_tests++; if (bif.state !== 3'd2) begin n_fail++; $display("FAIL abort_pre_state: got %0d want 2", bif.state); end
        #2 rstz = 1'b0;
        #1;
        n_tests++; if (bif.state !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", bif.state); end
        n_tests++; if (bif.txbit !== 1'b0 || bif.fk !== 7'd0 || bif.sync_hit_p !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: tx=%0b fk=%0d hit=%0b want 0/0/0", bif.txbit, bif.fk, bif.sync_hit_p); end
        n_tests++; if (dut.clkn !== 28'd0 || dut.us !== 10'd0) begin
            n_fail++; $display("FAIL abort_counters: clkn=%0h us=%0d want 0/0", dut.clkn, dut.us); end
        @(negedge clk_6M);
        rstz = 1'b1;
    endtask

    initial begin
        bif.regi_isMaster = 1'b0;
        bif.regi_time_base_offset = 28'd0;
        bif.regi_slave_offset = 28'd0;
        bif.regi_InquiryEnable_oneshot = 1'b0;
        bif.regi_PageEnable_oneshot = 1'b0;
        bif.regi_InquiryScanEnable_oneshot = 1'b0;
        bif.regi_PageScanEnable_oneshot = 1'b0;
        bif.regi_Page_Timeout = 16'd0;
        bif.regi_Tiswindow = 16'd0;
        bif.regi_Tpswindow = 16'd0;
        bif.regi_syncword_GIAC = GIAC;
        bif.regi_syncword_DAC = DAC;
        bif.regi_correthreshold = 6'd60;
        bif.rxbit = 1'b0;
        test_reset();
        test_clk_offsets();
        test_role_ignore();
        test_inquiry();
        test_page();
        test_scan_correlator(1'b0, 4, 100, 60, 1);
        test_scan_correlator(1'b0, 5, 2, 60, 0);
        test_scan_correlator(1'b1, 0, 100, 63, 1);
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
